// File: rtl/spi_tx_pkg.sv
// spi_tx_pkg: shared types and widths for the FIFO-to-SPI transmit drain.
package spi_tx_pkg;
   localparam int SPI_DATA_WIDTH = 16;
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, GAP} spi_tx_state_e;
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period counter producing sclk rise/fall ticks while run is high.
module spi_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic rise_tick,
   output logic fall_tick
);
   localparam int DW = $clog2(CLK_DIV + 1);
   logic [DW-1:0] div_q, div_d;
   logic          phase_q, phase_d, last;
   assign last = div_q == DW'(CLK_DIV - 1);
   always_comb begin
      div_d   = last ? '0 : div_q + 1'b1;
      phase_d = last ? ~phase_q : phase_q;
   end
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         div_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
      end
   end
   // phase_q low means sclk is in its low half, so the tick ending it is a rise
   assign rise_tick = run && last && !phase_q;
   assign fall_tick = run && last && phase_q;
endmodule

// File: rtl/fifo_spi_tx.sv
// fifo_spi_tx: drains the transmit FIFO one word at a time and shifts it out as an SPI mode-0 master.
module fifo_spi_tx
   import spi_tx_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_DATA_WIDTH,
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  ss_n,
   output logic                  busy,
   output logic                  word_done
);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   spi_tx_state_e         state_q, state_d;
   logic [DATA_WIDTH-1:0] sh_q;
   logic [BW-1:0]         bit_q;
   logic [GW-1:0]         gap_q;
   logic                  sclk_q, mosi_q, ss_n_q, done_q;
   logic                  rise, fall, last_bit, gap_last, go;
   assign last_bit = bit_q == BW'(DATA_WIDTH - 1);
   assign gap_last = gap_q == GW'(GAP_CYCLES - 1);
   assign go       = enable && !fifo_empty;
   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk      (clk),
      .rst      (rst),
      .run      (state_q == SHIFT),
      .rise_tick(rise),
      .fall_tick(fall)
   );
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   // FIFO is never re-checked in FETCH: this block is its only reader
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = go ? FETCH : IDLE;
         FETCH:   state_d = LOAD;
         LOAD:    state_d = SHIFT;
         SHIFT:   state_d = (fall && last_bit) ? GAP : SHIFT;
         GAP:     state_d = gap_last ? (go ? FETCH : IDLE) : GAP;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      fifo_rd_en = state_q == FETCH;
      busy       = state_q != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q   <= '0;
         bit_q  <= '0;
         gap_q  <= '0;
         sclk_q <= 1'b0;
         mosi_q <= 1'b0;
         ss_n_q <= 1'b1;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         gap_q  <= (state_q == GAP) ? gap_q + 1'b1 : '0;
         if (state_q == LOAD) begin
            sh_q   <= fifo_dout;
            mosi_q <= fifo_dout[DATA_WIDTH-1];
            ss_n_q <= 1'b0;
            sclk_q <= 1'b0;
            bit_q  <= '0;
         end else if (rise) begin
            sclk_q <= 1'b1;
         end else if (fall) begin
            sclk_q <= 1'b0;
            if (last_bit) begin
               ss_n_q <= 1'b1;
               mosi_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               bit_q  <= bit_q + 1'b1;
               sh_q   <= {sh_q[DATA_WIDTH-2:0], 1'b0};
               mosi_q <= sh_q[DATA_WIDTH-2];
            end
         end
      end
   end
   assign sclk      = sclk_q;
   assign mosi      = mosi_q;
   assign ss_n      = ss_n_q;
   assign word_done = done_q;
endmodule

// File: tb/tb_fifo_spi_tx.sv
// tb_fifo_spi_tx: scoreboard bench; a FIFO model feeds the DUT and an SPI monitor decodes frames.
module tb_fifo_spi_tx;
   localparam int FRAME = 64;
   localparam int GAPH  = 4;
   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
   logic        fifo_empty, fifo_rd_en, sclk, mosi, ss_n, busy, word_done;
   logic [15:0] fifo_dout = 16'h0;
   logic [15:0] mem [0:255];
   int          wr_ptr = 0, rd_ptr = 0;
   logic [15:0] exp_q [$];
   int          gap_q [$];
   int          checks = 0, errors = 0;
   int          rd_cnt = 0, done_cnt = 0, rise_cnt = 0;

   fifo_spi_tx dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .fifo_empty(fifo_empty),
      .fifo_dout (fifo_dout),
      .fifo_rd_en(fifo_rd_en),
      .sclk      (sclk),
      .mosi      (mosi),
      .ss_n      (ss_n),
      .busy      (busy),
      .word_done (word_done)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk)
      if (fifo_rd_en && wr_ptr != rd_ptr) begin
         fifo_dout <= mem[rd_ptr[7:0]];
         rd_ptr    <= rd_ptr + 1;
      end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic push(input logic [15:0] w);
      mem[wr_ptr[7:0]] = w;
      wr_ptr++;
      exp_q.push_back(w);
   endtask

   task automatic wait_done(input int target, input int budget);
      int c = 0;
      while (done_cnt < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("wait_word_done", 32'(done_cnt >= target), 1);
   endtask

   task automatic wait_rise(input int target, input int budget);
      int c = 0;
      while (rise_cnt < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("wait_sclk_rise", 32'(rise_cnt >= target), 1);
   endtask

   // SPI slave model: samples mosi on each sclk rise while ss_n is low
   logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, in_frame = 1'b0, mode_ok = 1'b1;
   logic [15:0] sh = 16'h0;
   int          bits = 0, lo_len = 0, hi_len = 0;
   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         hi_len   = 0;
      end else begin
         if (fifo_rd_en) rd_cnt++;
         if (word_done) done_cnt++;
         if (!ss_n && prev_ss) begin
            gap_q.push_back(hi_len);
            in_frame = 1'b1;
            bits     = 0;
            lo_len   = 0;
            mode_ok  = 1'b1;
         end
         if (!ss_n) begin
            lo_len++;
            if (sclk && !prev_sclk) begin
               sh = {sh[14:0], mosi};
               bits++;
               rise_cnt++;
            end
            if (!prev_ss && mosi != prev_mosi && !(prev_sclk && !sclk)) mode_ok = 1'b0;
         end
         if (ss_n && !prev_ss && in_frame) begin
            chk("frame_bits", bits, 16);
            chk("frame_len", lo_len, FRAME);
            chk("frame_word_done", word_done, 1);
            chk("frame_mode0", mode_ok, 1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL frame_word got %0h expected none", sh);
            end else begin
               chk("frame_word", sh, exp_q.pop_front());
            end
            in_frame = 1'b0;
            hi_len   = 0;
         end
         if (ss_n) hi_len++;
      end
      prev_ss   = ss_n;
      prev_sclk = sclk;
      prev_mosi = mosi;
   end

   initial begin
      int b0, r0, d0, n;
      int bad_rd, bad_busy, bad_ss;
      // reset with a word waiting and enable high
      push(16'hA5C3);
      enable = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_rd_en", fifo_rd_en, 0);
         chk("rst_ss_n", ss_n, 1);
      end
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_word_done", word_done, 0);
      // single word with start latency
      rst = 1'b0;
      @(negedge clk);
      chk("lat_rd_en", fifo_rd_en, 1);
      @(negedge clk);
      chk("lat_rd_en_once", fifo_rd_en, 0);
      chk("lat_ss_n_load", ss_n, 1);
      @(negedge clk);
      chk("lat_ss_n", ss_n, 0);
      chk("lat_mosi_msb", mosi, 1);
      @(negedge clk);
      chk("lat_sclk_low", sclk, 0);
      @(negedge clk);
      chk("lat_sclk_rise", sclk, 1);
      wait_done(1, 200);
      chk("single_rd_cnt", rd_cnt, 1);
      chk("single_rises", rise_cnt, 16);
      repeat (10) @(negedge clk);
      chk("single_busy", busy, 0);
      chk("single_done_cnt", done_cnt, 1);
      // back-to-back
      gap_q.delete();
      r0 = rd_cnt;
      d0 = done_cnt;
      push(16'h0001);
      push(16'h8000);
      push(16'hFFFF);
      wait_done(d0 + 3, 400);
      chk("b2b_rd_cnt", rd_cnt - r0, 3);
      chk("b2b_done_cnt", done_cnt - d0, 3);
      chk("b2b_gap_n", gap_q.size(), 3);
      if (gap_q.size() == 3) begin
         chk("b2b_gap1", gap_q[1], GAPH);
         chk("b2b_gap2", gap_q[2], GAPH);
      end
      repeat (10) @(negedge clk);
      // enable drop mid-frame with a second word still queued
      r0 = rd_cnt;
      d0 = done_cnt;
      b0 = rise_cnt;
      push(16'h1234);
      push(16'h5555);
      wait_rise(b0 + 6, 200);
      enable = 1'b0;
      wait_done(d0 + 1, 200);
      repeat (20) @(negedge clk);
      chk("drop_rd_cnt", rd_cnt - r0, 1);
      chk("drop_done_cnt", done_cnt - d0, 1);
      chk("drop_busy", busy, 0);
      chk("drop_rises", rise_cnt - b0, 16);
      // reset mid-frame: the popped 5555 is lost, 0F0F follows
      r0 = rd_cnt;
      d0 = done_cnt;
      b0 = rise_cnt;
      push(16'h0F0F);
      enable = 1'b1;
      wait_rise(b0 + 8, 200);
      rst = 1'b1;
      void'(exp_q.pop_front());
      @(negedge clk);
      chk("midrst_ss_n", ss_n, 1);
      chk("midrst_sclk", sclk, 0);
      chk("midrst_busy", busy, 0);
      rst = 1'b0;
      wait_done(d0 + 1, 200);
      chk("midrst_rd_cnt", rd_cnt - r0, 2);
      repeat (10) @(negedge clk);
      // randomized batches
      for (int k = 0; k < 4; k++) begin
         d0 = done_cnt;
         n  = $urandom_range(1, 6);
         for (int j = 0; j < n; j++) push(16'($urandom));
         wait_done(d0 + n, n * 80 + 50);
         repeat ($urandom_range(0, 10)) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      // empty FIFO with enable held
      bad_rd = 0;
      bad_busy = 0;
      bad_ss = 0;
      repeat (20) begin
         @(negedge clk);
         if (fifo_rd_en) bad_rd++;
         if (busy) bad_busy++;
         if (!ss_n) bad_ss++;
      end
      chk("empty_rd_en", bad_rd, 0);
      chk("empty_busy", bad_busy, 0);
      chk("empty_ss_n", bad_ss, 0);
      chk("exp_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
